// File: rtl/rnbip_rf_pkg.sv
// Shared encodings for the register-file sequencer: op codes, enable/mux codes, FSM states.
package rnbip_rf_pkg;

   typedef enum logic [1:0] {
      OP_LOAD = 2'd0,
      OP_MOVE = 2'd1,
      OP_READ = 2'd2,
      OP_ALU  = 2'd3
   } op_t;

   localparam logic [1:0] EN_IDLE = 2'b00;
   localparam logic [1:0] EN_WR   = 2'b01;
   localparam logic [1:0] EN_RD   = 2'b11;

   localparam logic [2:0] MUX_NONE = 3'b000;
   localparam logic [2:0] MUX_REG  = 3'b001;
   localparam logic [2:0] MUX_OR2  = 3'b010;
   localparam logic [2:0] MUX_ALU  = 3'b011;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WR   = 2'd1,
      S_RD   = 2'd2,
      S_RDV  = 2'd3
   } state_t;

endpackage

// File: rtl/regfile_ctrl_if.sv
// Decode-request and ALU write-back handshake channels of the register-file sequencer.
interface regfile_ctrl_if #(
   parameter int AW = 3
) ();

   logic          op_valid;
   logic          op_ready;
   logic [1:0]    op_code;
   logic [AW-1:0] op_dst;
   logic [AW-1:0] op_src;
   logic          wb_valid;
   logic          wb_ready;
   logic [AW-1:0] wb_dst;

   modport master (
      output op_valid, op_code, op_dst, op_src, wb_valid, wb_dst,
      input  op_ready, wb_ready
   );

   modport slave (
      input  op_valid, op_code, op_dst, op_src, wb_valid, wb_dst,
      output op_ready, wb_ready
   );

endinterface

// File: rtl/rf_scoreboard.sv
// Per-register busy bits for in-flight ALU results, with two hazard lookup ports.
module rf_scoreboard #(
   parameter int NREG = 8,
   parameter int AW   = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            set_en,
   input  logic [AW-1:0]   set_idx,
   input  logic            clr_en,
   input  logic [AW-1:0]   clr_idx,
   input  logic [AW-1:0]   look_a,
   input  logic [AW-1:0]   look_b,
   output logic            busy_a,
   output logic            busy_b,
   output logic [NREG-1:0] busy_vec
);

   logic [NREG-1:0] busy;

   // Clear is applied last so it overrides a set to the same index.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy <= '0;
      end else begin
         if (set_en) busy[set_idx] <= 1'b1;
         if (clr_en) busy[clr_idx] <= 1'b0;
      end
   end

   assign busy_a   = busy[look_a];
   assign busy_b   = busy[look_b];
   assign busy_vec = busy;

endmodule

// File: rtl/regfile_ctrl.sv
// Register-file sequencer/arbiter: write-back has priority over decode; busy scoreboard blocks hazards.
// Optional statistics counters are built when RFC_STATS_EN is defined.
module regfile_ctrl
   import rnbip_rf_pkg::*;
#(
   parameter int NREG  = 8,
   parameter int AW    = 3
`ifdef RFC_STATS_EN
   ,
   parameter int CNT_W = 16
`endif
) (
   input  logic            clk,
   input  logic            rst,
   regfile_ctrl_if.slave   bus,
   output logic            alu_start,
   output logic            rd_valid,
   output logic [1:0]      rf_enab,
   output logic [2:0]      rf_mux_sel,
   output logic [AW-1:0]   rf_reg_sel,
   output logic [AW-1:0]   rf_seg,
   output logic [NREG-1:0] busy_vec
`ifdef RFC_STATS_EN
   ,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] op_cnt
`endif
);

   state_t        state, state_nxt;
   op_t           op;
   logic          busy_dst, busy_src, hazard;
   logic          op_acc, wb_acc;
   logic [1:0]    enab_nxt;
   logic [2:0]    mux_nxt;
   logic [AW-1:0] reg_sel_nxt, seg_nxt;
   logic          alu_start_nxt, rd_valid_nxt;

   assign op = op_t'(bus.op_code);

   rf_scoreboard #(.NREG(NREG), .AW(AW)) u_sb (
      .clk      (clk),
      .rst      (rst),
      .set_en   (op_acc && (op == OP_ALU)),
      .set_idx  (bus.op_dst),
      .clr_en   (wb_acc),
      .clr_idx  (bus.wb_dst),
      .look_a   (bus.op_dst),
      .look_b   (bus.op_src),
      .busy_a   (busy_dst),
      .busy_b   (busy_src),
      .busy_vec (busy_vec)
   );

   always_comb begin
      hazard = 1'b0;
      case (op)
         OP_LOAD: hazard = busy_dst;
         OP_MOVE: hazard = busy_src | busy_dst;
         OP_READ: hazard = busy_src;
         OP_ALU:  hazard = busy_dst;
         default: hazard = 1'b0;
      endcase
   end

   assign bus.wb_ready = (state == S_IDLE);
   assign bus.op_ready = (state == S_IDLE) && !bus.wb_valid && !hazard;

   always_comb begin
      state_nxt     = state;
      enab_nxt      = EN_IDLE;
      mux_nxt       = rf_mux_sel;
      reg_sel_nxt   = rf_reg_sel;
      seg_nxt       = rf_seg;
      alu_start_nxt = 1'b0;
      rd_valid_nxt  = 1'b0;
      op_acc        = 1'b0;
      wb_acc        = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.wb_valid) begin
               wb_acc    = 1'b1;
               state_nxt = S_WR;
               enab_nxt  = EN_WR;
               mux_nxt   = MUX_ALU;
               seg_nxt   = bus.wb_dst;
            end else if (bus.op_valid && !hazard) begin
               op_acc = 1'b1;
               case (op)
                  OP_LOAD: begin
                     state_nxt = S_WR;
                     enab_nxt  = EN_WR;
                     mux_nxt   = MUX_OR2;
                     seg_nxt   = bus.op_dst;
                  end
                  OP_MOVE: begin
                     state_nxt   = S_WR;
                     enab_nxt    = EN_WR;
                     mux_nxt     = MUX_REG;
                     reg_sel_nxt = bus.op_src;
                     seg_nxt     = bus.op_dst;
                  end
                  OP_READ: begin
                     state_nxt = S_RD;
                     enab_nxt  = EN_RD;
                     seg_nxt   = bus.op_src;
                  end
                  default: alu_start_nxt = 1'b1;
               endcase
            end
         end
         S_WR:  state_nxt = S_IDLE;
         // Second read cycle: address held, file output now valid.
         S_RD: begin
            state_nxt    = S_RDV;
            enab_nxt     = EN_RD;
            rd_valid_nxt = 1'b1;
         end
         S_RDV: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         rf_enab    <= EN_IDLE;
         rf_mux_sel <= MUX_NONE;
         rf_reg_sel <= '0;
         rf_seg     <= '0;
         alu_start  <= 1'b0;
         rd_valid   <= 1'b0;
      end else begin
         state      <= state_nxt;
         rf_enab    <= enab_nxt;
         rf_mux_sel <= mux_nxt;
         rf_reg_sel <= reg_sel_nxt;
         rf_seg     <= seg_nxt;
         alu_start  <= alu_start_nxt;
         rd_valid   <= rd_valid_nxt;
      end
   end

`ifdef RFC_STATS_EN
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
         op_cnt    <= '0;
      end else begin
         if (bus.op_valid && !bus.op_ready) stall_cnt <= sat_inc(stall_cnt);
         if (op_acc || wb_acc)              op_cnt    <= sat_inc(op_cnt);
      end
   end
`endif

endmodule
